// File: rtl/cam_axis_pkg.sv
// Shared types and constants for the camera-to-AXI4-Stream bridge.
package cam_axis_pkg;

   typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DROP} cam_state_t;

   localparam int FLAG_W = 2;   // {tuser, tlast} stored beside each pixel
   localparam int CNT_W  = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/cam_axis_bridge_if.sv
// AXI4-Stream video bus carried by the bridge output.
interface cam_axis_bridge_if #(parameter int DATA_W = 16);

   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tuser;
   logic              tlast;

   modport master (output tdata, tvalid, tuser, tlast, input tready);
   modport slave  (input tdata, tvalid, tuser, tlast, output tready);

endinterface

// File: rtl/cam_axis_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible while !empty.
module cam_axis_fifo #(
   parameter int W     = 18,
   parameter int DEPTH = 16
) (
   input  logic         pclk,
   input  logic         resetn,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   always_ff @(posedge pclk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge pclk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cam_axis_bridge.sv
// Parallel camera port (FV/LV/D_IN) to AXI4-Stream video master with geometry checks.
// Define CAM_AXIS_STATS_EN to add frame_cnt / drop_cnt / last_line_len outputs.
module cam_axis_bridge
   import cam_axis_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int WIDTH      = 640,
   parameter int HEIGHT     = 480,
   parameter int FIFO_DEPTH = 1024
) (
   input  logic              pclk,
   input  logic              resetn,
   input  logic [DATA_W-1:0] D_IN,
   input  logic              FV,
   input  logic              LV,
   cam_axis_bridge_if.master m_axis,
   output logic              overflow,
   output logic              line_len_err,
   output logic              frame_len_err
`ifdef CAM_AXIS_STATS_EN
   ,
   output logic [31:0]       frame_cnt,
   output logic [15:0]       drop_cnt,
   output logic [15:0]       last_line_len
`endif
);

   localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] HEIGHT_C = CNT_W'(HEIGHT);
   localparam int               FW       = DATA_W + FLAG_W;

   // Samples travel s0 -> s1 -> s2; the pixel in s2 is written with s1 as its lookahead.
   // FV resets high so a frame already running at reset is never seen as a rising edge.
   logic [3:0]        fv_sr;
   logic [2:0]        lv_sr;
   logic [DATA_W-1:0] d0, d1, d2;

   always_ff @(posedge pclk) begin
      if (!resetn) begin
         fv_sr <= '1;
         lv_sr <= '0;
         d0    <= '0;
         d1    <= '0;
         d2    <= '0;
      end else begin
         fv_sr <= {fv_sr[2:0], FV};
         lv_sr <= {lv_sr[1:0], LV};
         d0    <= D_IN;
         d1    <= d0;
         d2    <= d1;
      end
   end

   logic act1, act2, rise, fall;
   assign act2 = fv_sr[2] & lv_sr[2];
   assign act1 = fv_sr[1] & lv_sr[1];
   assign rise = fv_sr[2] & ~fv_sr[3];
   assign fall = fv_sr[2] & ~fv_sr[1];

   cam_state_t      state, state_nxt;
   logic            sof_pend;
   logic            fifo_full, fifo_empty, fifo_rd, fifo_ok;
   logic [FW-1:0]   wr_data, rd_data;
   logic            in_frame, taking, wr_try, wr_en, blocked, drop;
   logic            line_chk, frame_chk, frame_end, tuser_bit;

   assign fifo_rd = ~fifo_empty & m_axis.tready;
   assign fifo_ok = ~fifo_full | fifo_rd;

   always_ff @(posedge pclk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!fv_sr[2]) state_nxt = ARMED;
         ARMED:   if (rise) state_nxt = fall ? ARMED : (blocked ? DROP : ACTIVE);
         ACTIVE:  if (fall) state_nxt = ARMED;
                  else if (blocked) state_nxt = DROP;
         DROP:    if (fall) state_nxt = ARMED;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      taking    = (state == ACTIVE) || (state == ARMED && rise);
      in_frame  = taking || (state == DROP);
      wr_try    = act2 & taking;
      wr_en     = wr_try & fifo_ok;
      blocked   = wr_try & ~fifo_ok;
      drop      = blocked | (act2 & (state == DROP));
      line_chk  = act2 & ~act1 & in_frame;
      frame_chk = fall & taking;
      frame_end = fall & in_frame;
      tuser_bit = sof_pend | (state == ARMED);
   end

   assign wr_data = {tuser_bit, ~act1, d2};

   cam_axis_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .pclk    (pclk),
      .resetn  (resetn),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (fifo_rd),
      .rd_data (rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign m_axis.tvalid = ~fifo_empty;
   assign m_axis.tdata  = fifo_empty ? '0 : rd_data[DATA_W-1:0];
   assign m_axis.tlast  = ~fifo_empty & rd_data[DATA_W];
   assign m_axis.tuser  = ~fifo_empty & rd_data[DATA_W+1];

   logic [CNT_W-1:0] pix_cnt, line_cnt, pix_now, line_now;
   assign pix_now  = sat_inc(pix_cnt);
   assign line_now = line_chk ? sat_inc(line_cnt) : line_cnt;

   always_ff @(posedge pclk) begin
      if (!resetn) begin
         pix_cnt       <= '0;
         line_cnt      <= '0;
         sof_pend      <= 1'b0;
         overflow      <= 1'b0;
         line_len_err  <= 1'b0;
         frame_len_err <= 1'b0;
`ifdef CAM_AXIS_STATS_EN
         frame_cnt     <= '0;
         drop_cnt      <= '0;
         last_line_len <= '0;
`endif
      end else begin
         line_len_err  <= 1'b0;
         frame_len_err <= 1'b0;
         if (drop) overflow <= 1'b1;

         if (line_chk) begin
            line_len_err <= (pix_now != WIDTH_C);
            pix_cnt      <= '0;
         end else if (act2 && in_frame) begin
            pix_cnt <= pix_now;
         end

         if (frame_end)     line_cnt <= '0;
         else if (line_chk) line_cnt <= line_now;
         if (frame_chk) frame_len_err <= (line_now != HEIGHT_C);

         if (frame_end || wr_en)        sof_pend <= 1'b0;
         else if (state == ARMED && rise) sof_pend <= 1'b1;

`ifdef CAM_AXIS_STATS_EN
         if (frame_end) frame_cnt     <= frame_cnt + 32'd1;
         if (drop)      drop_cnt      <= sat_inc(drop_cnt);
         if (line_chk)  last_line_len <= pix_now;
`endif
      end
   end

endmodule

// File: tb/tb_cam_axis_bridge.sv
// Directed bench for cam_axis_bridge (WIDTH=8, HEIGHT=4, FIFO_DEPTH=16).
module tb_cam_axis_bridge;

   localparam int DW  = 16;
   localparam int WID = 8;
   localparam int HGT = 4;
   localparam int DEP = 16;

   typedef logic [DW+1:0] beat_t;

   logic          pclk = 1'b0;
   logic          resetn = 1'b0;
   logic [DW-1:0] D_IN = '0;
   logic          FV = 1'b0;
   logic          LV = 1'b0;
   logic          overflow, line_len_err, frame_len_err;
`ifdef CAM_AXIS_STATS_EN
   logic [31:0]   frame_cnt;
   logic [15:0]   drop_cnt, last_line_len;
`endif

   cam_axis_bridge_if #(.DATA_W(DW)) axis ();

   cam_axis_bridge #(.DATA_W(DW), .WIDTH(WID), .HEIGHT(HGT), .FIFO_DEPTH(DEP)) dut (
      .pclk          (pclk),
      .resetn        (resetn),
      .D_IN          (D_IN),
      .FV            (FV),
      .LV            (LV),
      .m_axis        (axis),
      .overflow      (overflow),
      .line_len_err  (line_len_err),
      .frame_len_err (frame_len_err)
`ifdef CAM_AXIS_STATS_EN
      ,
      .frame_cnt     (frame_cnt),
      .drop_cnt      (drop_cnt),
      .last_line_len (last_line_len)
`endif
   );

   always #5 pclk = ~pclk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   beat_t exp_q[$];
   beat_t cap_q[$];
   beat_t cur;
   assign cur = {axis.tuser, axis.tlast, axis.tdata};

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   // 0: tready high, 1: toggle each cycle, 2: tready low
   int ready_mode = 0;
   always @(posedge pclk) begin
      #1;
      case (ready_mode)
         0:       axis.tready = 1'b1;
         1:       axis.tready = ~axis.tready;
         default: axis.tready = 1'b0;
      endcase
   end

   int    line_errs = 0;
   int    frame_errs = 0;
   bit    stall_pend = 1'b0;
   beat_t stall_beat;
   bit    lat_arm = 1'b0;
   int    lat_seen = 0;
   int    first_px_edge = 0;

   always @(negedge pclk) begin
      if (!resetn) begin
         stall_pend = 1'b0;
      end else begin
         if (line_len_err) line_errs++;
         if (frame_len_err) frame_errs++;
         if (stall_pend) check_val("stall hold", {axis.tvalid, cur}, {1'b1, stall_beat});
         if (lat_arm && axis.tvalid) begin
            lat_seen = cyc;
            lat_arm  = 1'b0;
         end
         if (axis.tvalid && axis.tready) cap_q.push_back(cur);
         stall_pend = axis.tvalid && !axis.tready;
         stall_beat = cur;
      end
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   int lens[8];

   // One frame; expected beats limited to the first 'keep'; optional reset at (rst_line, rst_px).
   task automatic cam_frame(input int nlines, input bit same, input int keep, input int base,
                            input int rst_line, input int rst_px);
      int idx = 0;
      bit dead = 1'b0;
      FV = 1'b1;
      if (!same) begin
         tick();
         tick();
      end
      for (int l = 0; l < nlines; l++) begin
         LV = 1'b1;
         for (int p = 0; p < lens[l]; p++) begin
            if (l == rst_line && p == rst_px) begin
               resetn = 1'b0;
               dead   = 1'b1;
               exp_q.delete();
               cap_q.delete();
            end
            if (l == rst_line && p == rst_px + 1) begin
               check_val("rst tvalid", axis.tvalid, 0);
               check_val("rst tdata", axis.tdata, 0);
               check_val("rst flags", {axis.tuser, axis.tlast}, 0);
               check_val("rst overflow", overflow, 0);
            end
            if (l == rst_line && p == rst_px + 2) resetn = 1'b1;
            D_IN = DW'(base + idx);
            if (idx == 0) first_px_edge = cyc + 1;
            if (!dead && idx < keep)
               exp_q.push_back({idx == 0, p == lens[l] - 1, DW'(base + idx)});
            tick();
            idx++;
         end
         LV = 1'b0;
         if (l == nlines - 1) FV = 1'b0;
         tick();
         tick();
      end
      tick();
      tick();
   endtask

   task automatic drain_cmp(input string tag);
      int w = 0;
      int n;
      while (cap_q.size() < exp_q.size() && w < 400) begin
         tick();
         w++;
      end
      repeat (4) tick();
      check_val({tag, " count"}, cap_q.size(), exp_q.size());
      n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check_val($sformatf("%s beat%0d", tag, i), cap_q[i], exp_q[i]);
      cap_q.delete();
      exp_q.delete();
   endtask

   task automatic set_lens(input int a, input int b, input int c, input int d);
      lens[0] = a; lens[1] = b; lens[2] = c; lens[3] = d;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      check_val("reset tvalid", axis.tvalid, 0);
      check_val("reset tdata", axis.tdata, 0);
      check_val("reset flags", {axis.tuser, axis.tlast}, 0);
      check_val("reset overflow", overflow, 0);
      check_val("reset errs", {line_len_err, frame_len_err}, 0);
      resetn = 1'b1;
      repeat (5) tick();

      // full-rate frame, latency of the first pixel
      set_lens(8, 8, 8, 8);
      lat_arm = 1'b1;
      cam_frame(4, 1'b0, 99, 0, -1, -1);
      drain_cmp("t1");
      check_val("t1 latency", lat_seen - first_px_edge, 3);
      check_val("t1 line errs", line_errs, 0);
      check_val("t1 frame errs", frame_errs, 0);
      check_val("t1 overflow", overflow, 0);

      // toggling backpressure
      ready_mode = 1;
      cam_frame(4, 1'b0, 99, 0, -1, -1);
      drain_cmp("t2");
      ready_mode = 0;
      check_val("t2 overflow", overflow, 0);

      // no ready for a whole frame: 16 buffered, rest dropped
      ready_mode = 2;
      cam_frame(4, 1'b0, 16, 0, -1, -1);
      check_val("t3 none out", cap_q.size(), 0);
      check_val("t3 overflow", overflow, 1);
      check_val("t3 tvalid held", axis.tvalid, 1);
      ready_mode = 0;
      drain_cmp("t3 drain");
      cam_frame(4, 1'b0, 99, 100, -1, -1);
      drain_cmp("t3 next");
      check_val("t3 overflow sticky", overflow, 1);

      // short and long lines, then a short frame
      line_errs = 0;
      frame_errs = 0;
      set_lens(7, 9, 8, 8);
      cam_frame(4, 1'b0, 99, 200, -1, -1);
      drain_cmp("t4a");
      check_val("t4a line errs", line_errs, 2);
      check_val("t4a frame errs", frame_errs, 0);
      line_errs = 0;
      frame_errs = 0;
      set_lens(8, 8, 8, 8);
      cam_frame(3, 1'b0, 99, 300, -1, -1);
      drain_cmp("t4b");
      check_val("t4b line errs", line_errs, 0);
      check_val("t4b frame errs", frame_errs, 1);

      // reset in the middle of line 2, then a clean frame with FV/LV rising together
      cam_frame(4, 1'b0, 99, 64, 1, 3);
      drain_cmp("t5 rest");
      check_val("t5 overflow", overflow, 0);
      cam_frame(4, 1'b1, 99, 128, -1, -1);
      drain_cmp("t5 next");

`ifdef CAM_AXIS_STATS_EN
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      repeat (5) tick();
      cam_frame(4, 1'b0, 99, 0, -1, -1);
      drain_cmp("t6 f1");
      ready_mode = 2;
      cam_frame(4, 1'b0, 16, 0, -1, -1);
      ready_mode = 0;
      drain_cmp("t6 f2");
      cam_frame(4, 1'b0, 99, 0, -1, -1);
      drain_cmp("t6 f3");
      check_val("t6 frame_cnt", frame_cnt, 3);
      check_val("t6 drop_cnt", drop_cnt, 16);
      check_val("t6 last_line_len", last_line_len, 8);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
